lb_arbiter2: RTL and testbench

//  Shares one local-bus register-map slave between two local-bus requesters (e.g. APB and AXI-Lite bridges).

---
 rtl/lb_arb_pkg.sv | 22 ++
 rtl/lb_arb_rr2.sv | 24 ++
 rtl/lb_arbiter2.sv | 176 +++++++++++++++++
 tb/tb_lb_arbiter2.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lb_arb_pkg.sv
// Shared types and helpers for the two-requester local-bus arbiter.
package lb_arb_pkg;

    // Transaction state: idle, write in flight, or read in flight.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    // Grant and priority pointer both name one of the two requesters.
    typedef logic gnt_t;

    localparam gnt_t GNT_M0 = 1'b0;
    localparam gnt_t GNT_M1 = 1'b1;

    // The read wait counter must hold 0 .. timeout-1.
    function automatic int cnt_w(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/lb_arb_rr2.sv
// Two-way round-robin picker. The pointer only breaks ties when both
// requesters are asking at the same time.
module lb_arb_rr2
    import lb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_t       ptr,
    output gnt_t       gnt,
    output logic       valid
);

    // A lone requester always wins; a tie goes to the pointer side.
    always_comb begin
        valid = |req;
        gnt   = GNT_M0;
        case (req)
            2'b01:   gnt = GNT_M0;
            2'b10:   gnt = GNT_M1;
            2'b11:   gnt = ptr;
            default: gnt = GNT_M0;
        endcase
    end

endmodule

// File: rtl/lb_arbiter2.sv
// Shares one local-bus register-map slave between two requesters.
// One transaction is in flight at a time. Reads that the slave never
// answers are completed with TIMEOUT_VAL, so a requester cannot hang.
module lb_arbiter2
    import lb_arb_pkg::*;
#(
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 32,
    parameter int                RD_TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] TIMEOUT_VAL = 'hbadc0de,
    localparam int               STRB_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_waddr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic              m0_wen,
    output logic              m0_wready,
    input  logic [ADDR_W-1:0] m0_raddr,
    input  logic              m0_ren,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,

    input  logic [ADDR_W-1:0] m1_waddr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wen,
    output logic              m1_wready,
    input  logic [ADDR_W-1:0] m1_raddr,
    input  logic              m1_ren,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,

    output logic [ADDR_W-1:0] lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic [STRB_W-1:0] lb_wstrb,
    output logic              lb_wen,
    input  logic              lb_wready,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_ren,
    input  logic [DATA_W-1:0] lb_rdata,
    input  logic              lb_rvalid,
    output logic              rd_timeout
);

    localparam int               CNT_W    = cnt_w(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    gnt_t             gnt_q,   gnt_d;
    gnt_t             ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [1:0]  req;
    gnt_t        pick;
    logic        pick_vld;
    logic        pick_wen;

    assign req      = {m1_wen | m1_ren, m0_wen | m0_ren};
    assign pick_wen = (pick == GNT_M1) ? m1_wen : m0_wen;

    lb_arb_rr2 u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick),
        .valid (pick_vld)
    );

    // Next state: arbitrate in IDLE, hold the grant until handshake or timeout.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    state_d = pick_wen ? WR : RD;
                    cnt_d   = '0;
                end
            end
            WR: begin
                if (lb_wready) begin
                    state_d = IDLE;
                    ptr_d   = ~gnt_q;
                end
            end
            RD: begin
                if (lb_rvalid || (cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    ptr_d   = ~gnt_q;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_M0;
            ptr_q   <= GNT_M0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode from the registered state. Handshakes pass straight
    // through so the requester sees ready/valid in the slave's cycle; all
    // outputs are held at 0 while rst is high so no pulse escapes a reset.
    logic              rd_done;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        lb_waddr   = '0;
        lb_wdata   = '0;
        lb_wstrb   = '0;
        lb_wen     = 1'b0;
        lb_raddr   = '0;
        lb_ren     = 1'b0;
        rd_timeout = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        rd_done    = 1'b0;
        rd_data    = '0;
        if (!rst) begin
            case (state_q)
                WR: begin
                    lb_wen   = 1'b1;
                    lb_waddr = (gnt_q == GNT_M1) ? m1_waddr : m0_waddr;
                    lb_wdata = (gnt_q == GNT_M1) ? m1_wdata : m0_wdata;
                    lb_wstrb = (gnt_q == GNT_M1) ? m1_wstrb : m0_wstrb;
                    if (gnt_q == GNT_M1) m1_wready = lb_wready;
                    else                 m0_wready = lb_wready;
                end
                RD: begin
                    lb_ren   = 1'b1;
                    lb_raddr = (gnt_q == GNT_M1) ? m1_raddr : m0_raddr;
                    // Real data in the last wait cycle still beats the timeout.
                    if (lb_rvalid) begin
                        rd_done = 1'b1;
                        rd_data = lb_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        rd_done    = 1'b1;
                        rd_data    = TIMEOUT_VAL;
                        rd_timeout = 1'b1;
                    end
                    if (gnt_q == GNT_M1) begin
                        m1_rvalid = rd_done;
                        m1_rdata  = rd_data;
                    end else begin
                        m0_rvalid = rd_done;
                        m0_rdata  = rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lb_arbiter2.sv
// Randomized bench for lb_arbiter2. Requesters and the slave are played
// by the bench; a transaction-level model predicts which requester is
// served when, what appears on the slave bus and how each txn completes.
module tb_lb_arbiter2;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;
    localparam int RD_TIMEOUT = 16;
    localparam logic [DATA_W-1:0] TIMEOUT_VAL = 32'hbadc0de;
    localparam int NCYC       = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] waddr [2];
    logic [DATA_W-1:0] wdata [2];
    logic [STRB_W-1:0] wstrb [2];
    logic [ADDR_W-1:0] raddr [2];
    logic [1:0]        wen, ren;
    logic [1:0]        wready, rvalid;
    logic [DATA_W-1:0] rdata0, rdata1;

    logic [ADDR_W-1:0] lb_waddr, lb_raddr;
    logic [DATA_W-1:0] lb_wdata, lb_rdata;
    logic [STRB_W-1:0] lb_wstrb;
    logic              lb_wen, lb_ren, lb_wready, lb_rvalid, rd_timeout;

    lb_arbiter2 #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(RD_TIMEOUT), .TIMEOUT_VAL(TIMEOUT_VAL)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_waddr(waddr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wen(wen[0]),
        .m0_wready(wready[0]), .m0_raddr(raddr[0]), .m0_ren(ren[0]),
        .m0_rdata(rdata0), .m0_rvalid(rvalid[0]),
        .m1_waddr(waddr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wen(wen[1]),
        .m1_wready(wready[1]), .m1_raddr(raddr[1]), .m1_ren(ren[1]),
        .m1_rdata(rdata1), .m1_rvalid(rvalid[1]),
        .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen),
        .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren),
        .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid), .rd_timeout(rd_timeout)
    );

    // Outstanding requests per requester, with the cycle they were raised.
    typedef struct {
        bit                v;
        int                t;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [STRB_W-1:0] s;
    } wreq_t;
    typedef struct {
        bit                v;
        int                t;
        logic [ADDR_W-1:0] a;
    } rreq_t;

    wreq_t wq [2];
    rreq_t rq [2];

    // Transaction-level model state.
    bit busy, swr, force_both, did_wr_rst;
    int srv, ptr, start, lat, last_done, cyc;
    int n_chk = 0, n_fail = 0, n_wr = 0, n_rd = 0, n_to = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic post_wr(input int i);
        wq[i].v = 1'b1;
        wq[i].t = cyc;
        wq[i].a = ADDR_W'($urandom);
        wq[i].d = $urandom;
        wq[i].s = STRB_W'($urandom);
    endtask

    task automatic post_rd(input int i);
        rq[i].v = 1'b1;
        rq[i].t = cyc;
        rq[i].a = ADDR_W'($urandom);
    endtask

    // Requesters reset with the arbiter; priority returns to m0.
    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wq[i].v = 1'b0;
            rq[i].v = 1'b0;
            wen[i]  = 1'b0;
            ren[i]  = 1'b0;
        end
        lb_wready = 1'b0;
        lb_rvalid = 1'b0;
        @(posedge clk); #1;
        rst        = 1'b0;
        busy       = 1'b0;
        ptr        = 0;
        last_done  = cyc - 1;
        force_both = 1'b1;
    endtask

    initial begin
        bit vis [2];
        bit hit, done;
        logic [DATA_W-1:0] exp_rd;
        for (int i = 0; i < 2; i++) begin
            wq[i] = '{v: 1'b0, t: 0, a: '0, d: '0, s: '0};
            rq[i] = '{v: 1'b0, t: 0, a: '0};
            waddr[i] = '0; wdata[i] = '0; wstrb[i] = '0; raddr[i] = '0;
        end
        wen = '0; ren = '0;
        lb_wready = 1'b0; lb_rvalid = 1'b0; lb_rdata = '0;
        busy = 1'b0; swr = 1'b0; srv = 0; start = 0; lat = 0;
        did_wr_rst = 1'b0; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc != 0) begin
                @(posedge clk); #1;
            end
            // Occasionally reset with a transaction in flight; once during a stalled write.
            if (busy && ((swr && !did_wr_rst && cyc > NCYC / 3 && cyc != start + lat) ||
                         ($urandom % 300 == 0))) begin
                if (swr) did_wr_rst = 1'b1;
                do_reset();
            end

            // Arbitration decided in the previous (idle) cycle from the requests visible then.
            if (!busy && (cyc - 1 > last_done)) begin
                for (int i = 0; i < 2; i++)
                    vis[i] = (wq[i].v && wq[i].t <= cyc - 1) || (rq[i].v && rq[i].t <= cyc - 1);
                if (vis[0] || vis[1]) begin
                    srv   = (vis[0] && vis[1]) ? ptr : (vis[1] ? 1 : 0);
                    swr   = wq[srv].v && (wq[srv].t <= cyc - 1);
                    busy  = 1'b1;
                    start = cyc;
                    if (swr)                   lat = $urandom_range(0, 6);
                    else if ($urandom % 4 == 0) lat = RD_TIMEOUT - 1;
                    else                       lat = $urandom_range(0, RD_TIMEOUT + 3);
                end
            end

            // New requests: one-in-eight per idle channel, or both requesters after reset.
            for (int i = 0; i < 2; i++) begin
                if (force_both) begin
                    if ($urandom % 2 == 0) post_wr(i); else post_rd(i);
                end else begin
                    if (!wq[i].v && ($urandom % 8 == 0)) post_wr(i);
                    if (!rq[i].v && ($urandom % 8 == 0)) post_rd(i);
                end
                wen[i]   = wq[i].v;
                ren[i]   = rq[i].v;
                waddr[i] = wq[i].a;
                wdata[i] = wq[i].d;
                wstrb[i] = wq[i].s;
                raddr[i] = rq[i].a;
            end
            force_both = 1'b0;

            // Slave: answers the live transaction after lat cycles; the
            // handshake it should not be using toggles randomly.
            hit       = busy && (cyc == start + lat);
            lb_wready = (busy && swr)  ? hit : 1'($urandom);
            lb_rvalid = (busy && !swr) ? hit : 1'($urandom);
            lb_rdata  = $urandom;

            @(negedge clk);
            done   = busy && (swr ? hit : (hit || (cyc == start + RD_TIMEOUT - 1)));
            exp_rd = hit ? lb_rdata : TIMEOUT_VAL;

            chk("lb_wen",   64'(lb_wen),   64'(busy && swr));
            chk("lb_ren",   64'(lb_ren),   64'(busy && !swr));
            chk("lb_waddr", 64'(lb_waddr), (busy && swr)  ? 64'(wq[srv].a) : 64'd0);
            chk("lb_wdata", 64'(lb_wdata), (busy && swr)  ? 64'(wq[srv].d) : 64'd0);
            chk("lb_wstrb", 64'(lb_wstrb), (busy && swr)  ? 64'(wq[srv].s) : 64'd0);
            chk("lb_raddr", 64'(lb_raddr), (busy && !swr) ? 64'(rq[srv].a) : 64'd0);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m%0d_wready", i), 64'(wready[i]), 64'(done && swr && srv == i));
                chk($sformatf("m%0d_rvalid", i), 64'(rvalid[i]), 64'(done && !swr && srv == i));
            end
            chk("m0_rdata", 64'(rdata0), (done && !swr && srv == 0) ? 64'(exp_rd) : 64'd0);
            chk("m1_rdata", 64'(rdata1), (done && !swr && srv == 1) ? 64'(exp_rd) : 64'd0);
            chk("rd_timeout", 64'(rd_timeout), 64'(done && !swr && !hit));

            if (done) begin
                if (swr) begin
                    wq[srv].v = 1'b0;
                    n_wr++;
                end else begin
                    rq[srv].v = 1'b0;
                    if (hit) n_rd++; else n_to++;
                end
                busy      = 1'b0;
                last_done = cyc;
                ptr       = 1 - srv;
            end
        end

        // Every completion kind must have been exercised.
        chk("saw_writes",   64'(n_wr > 20), 64'd1);
        chk("saw_reads",    64'(n_rd > 10), 64'd1);
        chk("saw_timeouts", 64'(n_to > 2),  64'd1);
        chk("saw_wr_reset", 64'(did_wr_rst), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
